dht_sensor_ctrl: RTL and testbench

//  Parametrised single-wire humidity/temperature sensor controller, successor to the fixed DHT11 FSM.

---
 rtl/dht_sensor_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_dht_sensor_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl
//   Single-wire humidity/temperature sensor controller (DHT11 / DHT22).
//   Issues the host start pulse, times every sensor edge against a 1 us
//   tick, shifts in 40 data bits, verifies the checksum and decodes the
//   frame. An optional auto-repeat timer restarts a read after each done.
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 1-clk read request (ignored while busy)
//   sensor_type           0 = DHT11, 1 = DHT22, latched on accepted start
//   humidity/temperature  last valid readings
//   busy                  transaction in progress
//   dht_done              1-clk pulse at the end of every transaction
//   dht_valid             last transaction decoded correctly
//   err_timeout           sensor edge missing (sticky until next start)
//   err_checksum          checksum mismatch (sticky until next start)
//   debug                 current FSM state
//   dhtio                 sensor data line (open-drain style, hi-Z when released)
module dht_sensor_ctrl #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int START_LOW_US   = 19000,
    parameter int RELEASE_US     = 30,
    parameter int BIT_THRESH_US  = 40,
    parameter int TIMEOUT_US     = 200,
    parameter int AUTO_PERIOD_MS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sensor_type,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        busy,
    output logic        dht_done,
    output logic        dht_valid,
    output logic        err_timeout,
    output logic        err_checksum,
    output logic [3:0]  debug,
    inout  wire         dhtio
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_WAIT   = 4'd2,
        S_RESP_L = 4'd3,
        S_RESP_H = 4'd4,
        S_BIT_L  = 4'd5,
        S_BIT_H  = 4'd6,
        S_CHECK  = 4'd7,
        S_DONE   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    localparam int TICK_DIV  = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int US_MAX_A  = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int US_MAX    = (US_MAX_A > RELEASE_US) ? US_MAX_A : RELEASE_US;
    localparam int US_W      = $clog2(US_MAX + 2);
    localparam bit AUTO_EN   = (AUTO_PERIOD_MS != 0);
    localparam int AUTO_CLKS = AUTO_EN ? AUTO_PERIOD_MS * 1000 * TICK_DIV : 1;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [39:0]       shift_q, shift_d;
    logic              type_q, type_d;
    logic [15:0]       hum_q, hum_d, temp_q, temp_d;
    logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic              err_to_q, err_to_d, err_cs_q, err_cs_d;
    logic              io_oe_q, io_oe_d, io_out_q, io_out_d;
    logic              auto_arm_q, auto_arm_d;
    logic [31:0]       auto_cnt_q, auto_cnt_d;

    logic              rise, fall, tick, us_clr, auto_exp, timed_out;
    logic [7:0]        sum;
    logic [15:0]       mag;

    assign dhtio        = io_oe_q ? io_out_q : 1'bz;
    assign humidity     = hum_q;
    assign temperature  = temp_q;
    assign busy         = busy_q;
    assign dht_done     = done_q;
    assign dht_valid    = valid_q;
    assign err_timeout  = err_to_q;
    assign err_checksum = err_cs_q;
    assign debug        = state_q;

    always_comb begin
        sync1_d    = dhtio;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        type_d     = type_q;
        hum_d      = hum_q;
        temp_d     = temp_q;
        valid_d    = valid_q;
        err_to_d   = err_to_q;
        err_cs_d   = err_cs_q;
        auto_arm_d = auto_arm_q;
        auto_cnt_d = auto_cnt_q;
        us_clr     = 1'b0;

        rise      = sync2_q & ~prev_q;
        fall      = ~sync2_q & prev_q;
        tick      = (pre_q == PRE_W'(TICK_DIV - 1));
        timed_out = (us_q >= US_W'(TIMEOUT_US));
        auto_exp  = AUTO_EN && auto_arm_q && (auto_cnt_q == 32'(AUTO_CLKS - 1));
        sum       = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
        mag       = {1'b0, shift_q[22:16], shift_q[15:8]};

        if (auto_arm_q && state_q == S_IDLE && !auto_exp)
            auto_cnt_d = auto_cnt_q + 32'd1;

        case (state_q)
            S_IDLE: begin
                // start and auto expiry in the same clock start a single read
                if (start || auto_exp) begin
                    state_d    = S_START;
                    type_d     = sensor_type;
                    valid_d    = 1'b0;
                    err_to_d   = 1'b0;
                    err_cs_d   = 1'b0;
                    auto_arm_d = 1'b0;
                    auto_cnt_d = 32'd0;
                    bit_cnt_d  = 6'd0;
                    shift_d    = 40'd0;
                end
            end
            S_START: if (us_q == US_W'(START_LOW_US)) state_d = S_WAIT;
            S_WAIT:  if (us_q == US_W'(RELEASE_US))   state_d = S_RESP_L;
            S_RESP_L: begin
                if (fall)           state_d = S_RESP_H;
                else if (timed_out) begin state_d = S_ERR; err_to_d = 1'b1; end
            end
            S_RESP_H: begin
                // the falling edge that ends the response implies its rising edge
                if (fall)           state_d = S_BIT_L;
                else if (rise)      us_clr  = 1'b1;
                else if (timed_out) begin state_d = S_ERR; err_to_d = 1'b1; end
            end
            S_BIT_L: begin
                if (rise)           state_d = S_BIT_H;
                else if (fall)      us_clr  = 1'b1;
                else if (timed_out) begin state_d = S_ERR; err_to_d = 1'b1; end
            end
            S_BIT_H: begin
                if (fall) begin
                    shift_d   = {shift_q[38:0], (us_q > US_W'(BIT_THRESH_US))};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd39) ? S_CHECK : S_BIT_L;
                end else if (rise) begin
                    us_clr = 1'b1;
                end else if (timed_out) begin
                    state_d  = S_ERR;
                    err_to_d = 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                if (sum == shift_q[7:0]) begin
                    valid_d = 1'b1;
                    hum_d   = shift_q[39:24];
                    if (type_q)
                        temp_d = shift_q[23] ? (~mag + 16'd1) : mag;
                    else
                        temp_d = shift_q[23:8];
                end else begin
                    err_cs_d = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                state_d    = S_IDLE;
                auto_arm_d = AUTO_EN;
                auto_cnt_d = 32'd0;
            end
            default: state_d = S_IDLE;
        endcase

        // us counter restarts on every state change and is parked in IDLE
        if (state_d != state_q || state_q == S_IDLE) us_clr = 1'b1;
        if (us_clr) begin
            pre_d = '0;
            us_d  = '0;
        end else if (tick) begin
            pre_d = '0;
            us_d  = us_q + 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
            us_d  = us_q;
        end

        io_oe_d  = (state_d == S_IDLE) || (state_d == S_START) || (state_d == S_WAIT) ||
                   (state_d == S_DONE) || (state_d == S_ERR);
        io_out_d = (state_d != S_START);
        done_d   = (state_d == S_DONE) || (state_d == S_ERR);
        busy_d   = !((state_d == S_IDLE) || done_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            pre_q      <= '0;
            us_q       <= '0;
            bit_cnt_q  <= 6'd0;
            shift_q    <= 40'd0;
            type_q     <= 1'b0;
            hum_q      <= 16'd0;
            temp_q     <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_to_q   <= 1'b0;
            err_cs_q   <= 1'b0;
            io_oe_q    <= 1'b1;
            io_out_q   <= 1'b1;
            auto_arm_q <= 1'b0;
            auto_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            pre_q      <= pre_d;
            us_q       <= us_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            type_q     <= type_d;
            hum_q      <= hum_d;
            temp_q     <= temp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            err_to_q   <= err_to_d;
            err_cs_q   <= err_cs_d;
            io_oe_q    <= io_oe_d;
            io_out_q   <= io_out_d;
            auto_arm_q <= auto_arm_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// Directed bench for dht_sensor_ctrl: a behavioural sensor pulls the line
// low (open-drain) against a pull-up, scenario tasks check the results.
module tb_dht_sensor_ctrl;
    localparam int TICK      = 2;             // clocks per us at 2 MHz
    localparam int START_LOW = 100;
    localparam int RELEASE   = 30;
    localparam int THRESH    = 40;
    localparam int TMO       = 200;
    localparam int AUTO_MS   = 1;
    localparam int AUTO_CLKS = AUTO_MS * 1000 * TICK;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sensor_type = 1'b0;
    logic [15:0] humidity, temperature;
    logic        busy, dht_done, dht_valid, err_timeout, err_checksum;
    logic [3:0]  debug;
    wire         dhtio;
    logic        sens_low = 1'b0;
    int          n_cmp = 0, n_bad = 0, done_cnt = 0;

    assign dhtio = sens_low ? 1'b0 : 1'bz;
    pullup (dhtio);

    dht_sensor_ctrl #(
        .CLK_FREQ_HZ(2_000_000), .START_LOW_US(START_LOW), .RELEASE_US(RELEASE),
        .BIT_THRESH_US(THRESH), .TIMEOUT_US(TMO), .AUTO_PERIOD_MS(AUTO_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sensor_type(sensor_type),
        .humidity(humidity), .temperature(temperature), .busy(busy),
        .dht_done(dht_done), .dht_valid(dht_valid), .err_timeout(err_timeout),
        .err_checksum(err_checksum), .debug(debug), .dhtio(dhtio)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (dht_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic wait_us(input int n);
        repeat (n * TICK) @(negedge clk);
    endtask

    task automatic wait_line(input logic v, input int max_clk, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_clk; k++) begin
            if (dhtio === v) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; sens_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic typ);
        @(negedge clk); start = 1'b1; sensor_type = typ;
        @(negedge clk); start = 1'b0; sensor_type = 1'b0;
    endtask

    // Sensor side of one frame. start_bit: pulse start (type 1) during that
    // bit's low phase. rst_bit: assert rst_n during that bit's high phase and
    // return (lat = -2). Otherwise lat = negedges from last falling drive to done.
    task automatic send_frame(input logic [39:0] f, input int start_bit,
                              input int rst_bit, output int lat);
        bit ok;
        lat = -1;
        wait_line(1'b0, 1000, ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_start_pulse: no host low seen, want low within 1000 clks");
            return;
        end
        wait_line(1'b1, (START_LOW + 10) * TICK, ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_host_release: line stuck low, want high after %0d us", START_LOW);
            return;
        end
        wait_us(RELEASE + 5);
        sens_low = 1'b1; wait_us(80);
        sens_low = 1'b0; wait_us(80);
        for (int i = 39; i >= 0; i--) begin
            sens_low = 1'b1;
            if (i == start_bit) begin
                wait_us(5);
                start = 1'b1; sensor_type = 1'b1;
                @(negedge clk);
                start = 1'b0; sensor_type = 1'b0;
                wait_us(15);
            end else begin
                wait_us(20);
            end
            sens_low = 1'b0;
            if (i == rst_bit) begin
                wait_us(10);
                rst_n = 1'b0;
                lat = -2;
                return;
            end
            wait_us(f[i] ? 60 : 20);
        end
        sens_low = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dht_done === 1'b1 && lat < 0) lat = k;
        end
        wait_us(10);
        sens_low = 1'b0;
        wait_us(5);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({humidity, temperature} !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 00000000", {humidity, temperature});
        end
        n_cmp++;
        if ({busy, dht_done, dht_valid, err_timeout, err_checksum} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000",
                              {busy, dht_done, dht_valid, err_timeout, err_checksum});
        end
        n_cmp++;
        if (debug !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", debug); end
        n_cmp++;
        if (dhtio !== 1'b1) begin n_bad++; $display("FAIL reset_line: got %b want 1", dhtio); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || debug !== 4'd0) begin
            n_bad++; $display("FAIL reset_idle: got busy %b state %0d want 0 0", busy, debug);
        end
    endtask

    task automatic test_dht11();
        int lat, d0;
        d0 = done_cnt;
        pulse_start(1'b0);
        send_frame(40'h37_00_19_00_50, -1, -1, lat);
        n_cmp++;
        if (humidity !== 16'h3700) begin n_bad++; $display("FAIL dht11_hum: got %h want 3700", humidity); end
        n_cmp++;
        if (temperature !== 16'h1900) begin n_bad++; $display("FAIL dht11_temp: got %h want 1900", temperature); end
        n_cmp++;
        if ({dht_valid, err_timeout, err_checksum} !== 3'b100) begin
            n_bad++; $display("FAIL dht11_flags: got %b want 100", {dht_valid, err_timeout, err_checksum});
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL dht11_done_cnt: got %0d want 1", done_cnt - d0); end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL dht11_latency: got %0d want 4", lat); end
        n_cmp++;
        if (busy !== 1'b0 || dhtio !== 1'b1) begin
            n_bad++; $display("FAIL dht11_idle: got busy %b line %b want 0 1", busy, dhtio);
        end
    endtask

    task automatic test_dht22();
        int lat, d0;
        d0 = done_cnt;
        pulse_start(1'b1);
        n_cmp++;
        if (busy !== 1'b1 || dht_valid !== 1'b0) begin
            n_bad++; $display("FAIL dht22_accept: got busy %b valid %b want 1 0", busy, dht_valid);
        end
        send_frame(40'h02_8C_80_65_73, -1, -1, lat);
        n_cmp++;
        if (humidity !== 16'h028C) begin n_bad++; $display("FAIL dht22_hum: got %h want 028c", humidity); end
        n_cmp++;
        if (temperature !== 16'hFF9B) begin n_bad++; $display("FAIL dht22_temp: got %h want ff9b", temperature); end
        n_cmp++;
        if (dht_valid !== 1'b1 || done_cnt - d0 !== 1) begin
            n_bad++; $display("FAIL dht22_valid_done: got %b %0d want 1 1", dht_valid, done_cnt - d0);
        end
    endtask

    task automatic test_checksum();
        int lat, d0;
        d0 = done_cnt;
        pulse_start(1'b0);
        send_frame(40'h37_00_19_00_51, -1, -1, lat);
        n_cmp++;
        if ({dht_valid, err_timeout, err_checksum} !== 3'b001) begin
            n_bad++; $display("FAIL cs_flags: got %b want 001", {dht_valid, err_timeout, err_checksum});
        end
        n_cmp++;
        if ({humidity, temperature} !== 32'h028C_FF9B) begin
            n_bad++; $display("FAIL cs_hold: got %h want 028cff9b", {humidity, temperature});
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL cs_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_no_sensor();
        int el, d0;
        do_reset();
        d0 = done_cnt;
        el = -1;
        pulse_start(1'b0);
        for (int k = 1; k <= (START_LOW + RELEASE + TMO + 50) * TICK; k++) begin
            @(negedge clk);
            if (dht_done === 1'b1) begin el = k; break; end
        end
        n_cmp++;
        if (el < (START_LOW + RELEASE + TMO) * TICK || el > (START_LOW + RELEASE + TMO) * TICK + 8) begin
            n_bad++; $display("FAIL nosens_elapsed: got %0d clks want %0d..%0d", el,
                              (START_LOW + RELEASE + TMO) * TICK, (START_LOW + RELEASE + TMO) * TICK + 8);
        end
        @(negedge clk);
        n_cmp++;
        if ({dht_valid, err_timeout, err_checksum} !== 3'b010) begin
            n_bad++; $display("FAIL nosens_flags: got %b want 010", {dht_valid, err_timeout, err_checksum});
        end
        n_cmp++;
        if (busy !== 1'b0 || dhtio !== 1'b1 || debug !== 4'd0) begin
            n_bad++; $display("FAIL nosens_idle: got busy %b line %b state %0d want 0 1 0", busy, dhtio, debug);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL nosens_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_auto();
        int gap;
        bit seen;
        do_reset();
        pulse_start(1'b0);
        seen = 1'b0;
        for (int k = 0; k < (START_LOW + RELEASE + TMO + 50) * TICK; k++) begin
            @(negedge clk);
            if (dht_done === 1'b1) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL auto_first_done: got none want done pulse"); end
        gap = -1;
        for (int k = 1; k <= AUTO_CLKS + 50; k++) begin
            @(negedge clk);
            if (dhtio === 1'b0) begin gap = k; break; end
        end
        n_cmp++;
        if (gap < AUTO_CLKS - 3 || gap > AUTO_CLKS + 3) begin
            n_bad++; $display("FAIL auto_gap: got %0d clks want %0d +-3", gap, AUTO_CLKS);
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL auto_busy: got %b want 1", busy); end
        do_reset();
    endtask

    task automatic test_start_ignored();
        int lat, d0;
        do_reset();
        d0 = done_cnt;
        pulse_start(1'b0);
        send_frame(40'h02_8C_80_65_73, 20, -1, lat);
        n_cmp++;
        if ({humidity, temperature} !== 32'h028C_8065) begin
            n_bad++; $display("FAIL ign_data: got %h want 028c8065", {humidity, temperature});
        end
        n_cmp++;
        if (dht_valid !== 1'b1 || done_cnt - d0 !== 1) begin
            n_bad++; $display("FAIL ign_valid_done: got %b %0d want 1 1", dht_valid, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int lat, d0;
        d0 = done_cnt;
        pulse_start(1'b0);
        send_frame(40'h37_00_19_00_50, -1, 30, lat);
        @(negedge clk);
        n_cmp++;
        if (lat !== -2 || debug !== 4'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_state: got lat %0d state %0d busy %b want -2 0 0", lat, debug, busy);
        end
        n_cmp++;
        if (dhtio !== 1'b1 || humidity !== 16'h0) begin
            n_bad++; $display("FAIL rstmid_out: got line %b hum %h want 1 0000", dhtio, humidity);
        end
        rst_n = 1'b1;
        wait_us(50);
        n_cmp++;
        if (done_cnt !== d0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_dht11();
        test_dht22();
        test_checksum();
        test_no_sensor();
        test_auto();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got no completion want finish before 2 ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
